// File: rtl/i2s_rx_pkg.sv
// Shared types and defaults for the I2S receiver.
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_L = 2'd1,
    LEFT   = 2'd2,
    RIGHT  = 2'd3
  } rx_state_t;

  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_SLOT_W     = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  // Width of the per-slot bit counter: must hold 0..slot_w.
  function automatic int unsigned cnt_width(input int unsigned slot_w);
    return $clog2(slot_w + 1);
  endfunction

endpackage

// File: rtl/i2s_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; the head holds its last value when empty.
module i2s_rx_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == (AW+1)'(DEPTH));
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    hold_d   = hold_q;

    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      hold_d   = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    head  = empty ? hold_q : mem_q[rd_ptr_q];
    level = level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversampled pins, stereo deserialiser, FWFT pair FIFO, sticky error flags.
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned SLOT_W     = DEF_SLOT_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          enable,
  input  logic                          i2s_sclk,
  input  logic                          i2s_lrclk,
  input  logic                          i2s_datain,
  output logic [DATA_W-1:0]             sample_left,
  output logic [DATA_W-1:0]             sample_right,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          clear_flags
);

  localparam int unsigned CW = cnt_width(SLOT_W);

  rx_state_t           state_q, state_d;
  logic                sclk_meta_q, sclk_meta_d, sclk_s_q, sclk_s_d, sclk_prev_q, sclk_prev_d;
  logic                lr_meta_q, lr_meta_d, lr_s_q, lr_s_d;
  logic                din_meta_q, din_meta_d, din_s_q, din_s_d;
  logic                lr_d_q, lr_d_d, lr_dd_q, lr_dd_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [DATA_W-1:0]   left_q, left_d;
  logic                push_q, push_d;
  logic [2*DATA_W-1:0] push_data_q, push_data_d;
  logic                overflow_q, overflow_d;
  logic                frame_err_q, frame_err_d;

  logic                rise, slot_start, frame_set, drop;
  logic                fifo_full, fifo_empty;
  logic [2*DATA_W-1:0] fifo_head;

  always_comb begin
    sclk_meta_d = i2s_sclk;
    sclk_s_d    = sclk_meta_q;
    sclk_prev_d = sclk_s_q;
    lr_meta_d   = i2s_lrclk;
    lr_s_d      = lr_meta_q;
    din_meta_d  = i2s_datain;
    din_s_d     = din_meta_q;

    rise       = sclk_s_q & ~sclk_prev_q;
    // lr_d/lr_dd lag the pin by one and two SCLKs: a change between them
    // marks the MSB rise, one SCLK after the LRCLK edge.
    slot_start = rise & (lr_d_q != lr_dd_q);

    state_d     = state_q;
    lr_d_d      = lr_d_q;
    lr_dd_d     = lr_dd_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    left_d      = left_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    frame_set   = 1'b0;

    if (rise) begin
      lr_d_d  = lr_s_q;
      lr_dd_d = lr_d_q;
    end

    if (!enable) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sh_d      = '0;
    end else if (state_q == IDLE) begin
      state_d   = WAIT_L;
      bit_cnt_d = '0;
    end else if (slot_start) begin
      bit_cnt_d = CW'(1);
      sh_d      = '0;
      sh_d[0]   = din_s_q;
      case (state_q)
        WAIT_L: if (!lr_d_q) state_d = LEFT;
        LEFT: if (lr_d_q) begin
          if (bit_cnt_q >= CW'(DATA_W)) begin
            left_d  = sh_q;
            state_d = RIGHT;
          end else begin
            frame_set = 1'b1;
            state_d   = WAIT_L;
          end
        end
        RIGHT: if (!lr_d_q) begin
          state_d = LEFT;
          if (bit_cnt_q >= CW'(DATA_W)) begin
            push_d      = 1'b1;
            push_data_d = {left_q, sh_q};
          end else begin
            frame_set = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end else if (rise) begin
      if (bit_cnt_q == CW'(SLOT_W)) begin
        frame_set = 1'b1;
        state_d   = WAIT_L;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (bit_cnt_q < CW'(DATA_W)) sh_d = {sh_q[DATA_W-2:0], din_s_q};
      end
    end

    // A full FIFO is never empty, so a pop is exactly sample_ready.
    drop        = push_q & fifo_full & ~sample_ready;
    overflow_d  = (overflow_q & ~clear_flags) | drop;
    frame_err_d = (frame_err_q & ~clear_flags) | frame_set;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      sclk_meta_q <= 1'b0;
      sclk_s_q    <= 1'b0;
      sclk_prev_q <= 1'b0;
      lr_meta_q   <= 1'b0;
      lr_s_q      <= 1'b0;
      din_meta_q  <= 1'b0;
      din_s_q     <= 1'b0;
      lr_d_q      <= 1'b0;
      lr_dd_q     <= 1'b0;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      left_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_meta_q <= sclk_meta_d;
      sclk_s_q    <= sclk_s_d;
      sclk_prev_q <= sclk_prev_d;
      lr_meta_q   <= lr_meta_d;
      lr_s_q      <= lr_s_d;
      din_meta_q  <= din_meta_d;
      din_s_q     <= din_s_d;
      lr_d_q      <= lr_d_d;
      lr_dd_q     <= lr_dd_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      left_q      <= left_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  i2s_rx_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (sample_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign sample_valid = ~fifo_empty;
  assign sample_left  = fifo_head[2*DATA_W-1:DATA_W];
  assign sample_right = fifo_head[DATA_W-1:0];
  assign overflow     = overflow_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
module tb_i2s_rx;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        enable;
  logic        i2s_sclk;
  logic        i2s_lrclk;
  logic        i2s_datain;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic        sample_ready;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        frame_err;
  logic        clear_flags;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        carry;
  logic [15:0] lw [0:13];
  logic [15:0] rw [0:13];

  i2s_rx #(
    .DATA_W     (16),
    .SLOT_W     (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .enable       (enable),
    .i2s_sclk     (i2s_sclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_datain   (i2s_datain),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .frame_err    (frame_err),
    .clear_flags  (clear_flags)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One SCLK period (16 clk): low half then high half; LRCLK/data change at the falling edge.
  task automatic sbit(input logic lr, input logic d);
    i2s_sclk = 1'b0; i2s_lrclk = lr; i2s_datain = d;
    repeat (8) @(negedge clk_clk);
    i2s_sclk = 1'b1;
    repeat (8) @(negedge clk_clk);
  endtask

  // Periods first..last-1 of a slot; data lags LRCLK by one period (I2S format).
  task automatic send_bits(input logic ch, input logic [15:0] w, input int first, input int last);
    for (int i = first; i < last; i++) begin
      sbit(ch, carry);
      carry = (i < 16) ? w[15-i] : 1'b0;
    end
  endtask

  // Completes frame k (its left slot already has 2 periods sent) and starts the next left slot.
  task automatic finish_frame(input int k);
    send_bits(1'b0, lw[k], 2, 32);
    send_bits(1'b1, rw[k], 0, 32);
    send_bits(1'b0, lw[k+1], 0, 2);
  endtask

  task automatic pop_one();
    sample_ready = 1'b1;
    @(negedge clk_clk);
    sample_ready = 1'b0;
    @(negedge clk_clk);
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(negedge clk_clk);
    clear_flags = 1'b0;
    @(negedge clk_clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lw = '{16'hA55A, 16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6789,
           16'h789A, 16'h89AB, 16'h9ABC, 16'hABCD, 16'hBCDE, 16'hCDEF, 16'hDEF0};
    rw = '{16'h0F0F, 16'h8001, 16'h4002, 16'h2004, 16'h1008, 16'h0810, 16'h0420,
           16'h0240, 16'h0180, 16'hFFFF, 16'h0000, 16'hC3C3, 16'h3C3C, 16'h5A5A};
    carry = 1'b0;
    reset_reset = 1'b1; enable = 1'b0; i2s_sclk = 1'b0; i2s_lrclk = 1'b1;
    i2s_datain = 1'b0; sample_ready = 1'b0; clear_flags = 1'b0;
    repeat (4) @(negedge clk_clk);
    check_eq("rst_valid", 32'(sample_valid), 0);
    check_eq("rst_left",  32'(sample_left), 0);
    check_eq("rst_right", 32'(sample_right), 0);
    check_eq("rst_level", 32'(fifo_level), 0);
    check_eq("rst_ovf",   32'(overflow), 0);
    check_eq("rst_ferr",  32'(frame_err), 0);

    reset_reset = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk_clk);
    send_bits(1'b1, 16'h0000, 0, 4);

    // First pair.
    send_bits(1'b0, lw[0], 0, 2);
    finish_frame(0);
    check_eq("p0_valid", 32'(sample_valid), 1);
    check_eq("p0_left",  32'(sample_left), 32'h A55A);
    check_eq("p0_right", 32'(sample_right), 32'h0F0F);
    check_eq("p0_level", 32'(fifo_level), 1);
    pop_one();
    check_eq("p0_pop_valid", 32'(sample_valid), 0);
    check_eq("p0_pop_level", 32'(fifo_level), 0);
    check_eq("p0_hold_left", 32'(sample_left), 32'hA55A);

    // Six frames, nobody reading.
    for (int k = 1; k <= 6; k++) begin
      finish_frame(k);
      check_eq($sformatf("fill%0d_level", k), 32'(fifo_level), (k < 4) ? k : 4);
      check_eq($sformatf("fill%0d_ovf", k), 32'(overflow), (k >= 5) ? 1 : 0);
    end
    pulse_clear();
    check_eq("ovf_cleared", 32'(overflow), 0);

    // Pair 7 arrives while full, consumer pops exactly on the push cycle.
    send_bits(1'b0, lw[7], 2, 32);
    send_bits(1'b1, rw[7], 0, 32);
    send_bits(1'b0, lw[8], 0, 1);
    i2s_sclk = 1'b0; i2s_lrclk = 1'b0; i2s_datain = carry; carry = lw[8][14];
    repeat (8) @(negedge clk_clk);
    i2s_sclk = 1'b1;
    repeat (3) @(negedge clk_clk);
    sample_ready = 1'b1;
    @(negedge clk_clk);
    sample_ready = 1'b0;
    repeat (4) @(negedge clk_clk);
    check_eq("fullpop_level", 32'(fifo_level), 4);
    check_eq("fullpop_ovf",   32'(overflow), 0);
    check_eq("fullpop_head",  32'(sample_left), 32'(lw[2]));

    // Drain: 2, 3, 4, 7 (5 and 6 were dropped).
    check_eq("drain0_left", 32'(sample_left), 32'(lw[2])); check_eq("drain0_right", 32'(sample_right), 32'(rw[2])); pop_one();
    check_eq("drain1_left", 32'(sample_left), 32'(lw[3])); check_eq("drain1_right", 32'(sample_right), 32'(rw[3])); pop_one();
    check_eq("drain2_left", 32'(sample_left), 32'(lw[4])); check_eq("drain2_right", 32'(sample_right), 32'(rw[4])); pop_one();
    check_eq("drain3_left", 32'(sample_left), 32'(lw[7])); check_eq("drain3_right", 32'(sample_right), 32'(rw[7])); pop_one();
    check_eq("drain_valid", 32'(sample_valid), 0);
    check_eq("drain_level", 32'(fifo_level), 0);
    pop_one();
    check_eq("empty_pop_level", 32'(fifo_level), 0);

    // Short right slot (12 SCLKs).
    send_bits(1'b0, lw[8], 2, 32);
    send_bits(1'b1, rw[8], 0, 12);
    send_bits(1'b0, lw[9], 0, 2);
    check_eq("short_ferr",  32'(frame_err), 1);
    check_eq("short_level", 32'(fifo_level), 0);
    finish_frame(9);
    check_eq("after_short_level", 32'(fifo_level), 1);
    check_eq("after_short_left",  32'(sample_left), 32'(lw[9]));
    check_eq("after_short_right", 32'(sample_right), 32'(rw[9]));
    pulse_clear();
    check_eq("ferr_cleared", 32'(frame_err), 0);
    pop_one();

    // LRCLK low for 40 SCLKs.
    send_bits(1'b0, lw[10], 2, 40);
    check_eq("long_ferr",  32'(frame_err), 1);
    check_eq("long_state", 32'(dut.state_q), 1);
    send_bits(1'b1, rw[10], 0, 32);
    send_bits(1'b0, lw[11], 0, 2);
    check_eq("long_nopush", 32'(fifo_level), 0);
    finish_frame(11);
    check_eq("resume_level", 32'(fifo_level), 1);
    check_eq("resume_left",  32'(sample_left), 32'(lw[11]));
    check_eq("resume_right", 32'(sample_right), 32'(rw[11]));
    check_eq("resume_ferr",  32'(frame_err), 1);

    // Disable mid right slot with two pairs stored.
    finish_frame(12);
    check_eq("two_level", 32'(fifo_level), 2);
    send_bits(1'b0, lw[13], 2, 32);
    send_bits(1'b1, rw[13], 0, 10);
    enable = 1'b0;
    repeat (2) @(negedge clk_clk);
    check_eq("dis_state", 32'(dut.state_q), 0);
    check_eq("dis_level", 32'(fifo_level), 2);
    check_eq("dis_left",  32'(sample_left), 32'(lw[11]));
    pop_one();
    check_eq("dis_left2",  32'(sample_left), 32'(lw[12]));
    check_eq("dis_right2", 32'(sample_right), 32'(rw[12]));

    // Reset mid-frame.
    enable = 1'b1;
    send_bits(1'b1, rw[13], 10, 20);
    reset_reset = 1'b1;
    @(negedge clk_clk);
    check_eq("mrst_valid", 32'(sample_valid), 0);
    check_eq("mrst_left",  32'(sample_left), 0);
    check_eq("mrst_right", 32'(sample_right), 0);
    check_eq("mrst_level", 32'(fifo_level), 0);
    check_eq("mrst_ovf",   32'(overflow), 0);
    check_eq("mrst_ferr",  32'(frame_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
